hazard_sched: RTL and testbench

- Pipeline sequencing controller for the decode stage.
- Tracks in-flight register writes in a 3-entry shadow pipeline (EX/MEM/WB) and detects RAW hazards against decode's two source selects.
- Drives stall, bubble and flush controls for IF/ID and ID/EX, freezes on cache (memory) stall, and latches halt.
- Sits beside decode; consumes decode's control outputs; its controls gate the PC and pipeline registers.

---
 rtl/hazard_sched.sv | 148 ++++++++++++++
 tb/tb_hazard_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched.sv
// Decode-stage sequencing controller: tracks in-flight writes (EX/MEM/WB), stalls on RAW hazards,
// flushes on taken branches, freezes on memory stall and latches HALT. Option: HAZARD_SCHED_FORWARD_EN.
module hazard_sched #(
   parameter int MAX_MEM_STALL = 255,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [2:0]       id_read1sel,
   input  logic [2:0]       id_read2sel,
   input  logic             id_uses_r1,
   input  logic             id_uses_r2,
   input  logic             id_regwrite,
   input  logic [2:0]       id_writereg,
   input  logic             id_memread,
   input  logic             id_halt,
   input  logic             branch_taken,
   input  logic             mem_stall,
   output logic             stall_pc,
   output logic             stall_ifid,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err
);

   typedef struct packed {
      logic       v;
      logic [2:0] rd;
      logic       ld;
      logic       h;
   } shadow_t;

   typedef enum logic [1:0] {RUN, HAZ, MWAIT, HALT} state_t;

   state_t           state;
   shadow_t          sh_ex, sh_mem, sh_wb;
   logic [15:0]      wd_cnt;
   logic [16:0]      wd_inc;
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;
   logic             hazard;
   logic             halt_now;
   logic             hold_shadow;
   logic             shadow_unused;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // WB is never compared: the register file bypasses same-cycle writes.
   function automatic logic match_src(input logic [2:0] s, input shadow_t ex, input shadow_t mem);
`ifdef HAZARD_SCHED_FORWARD_EN
      return ex.v & ex.ld & (ex.rd == s) & (mem.v | ~mem.v);
`else
      return (ex.v & (ex.rd == s)) | (mem.v & (mem.rd == s));
`endif
   endfunction

   assign hazard = id_valid &
                   ((id_uses_r1 & match_src(id_read1sel, sh_ex, sh_mem)) |
                    (id_uses_r2 & match_src(id_read2sel, sh_ex, sh_mem)));

   assign halt_now      = (state == HALT) | sh_wb.h;
   assign hold_shadow   = halt_now | mem_stall;
   assign wd_inc        = {1'b0, wd_cnt} + 17'd1;
   assign shadow_unused = ^{sh_mem, sh_wb};

   always_comb begin
      stall_pc    = 1'b0;
      stall_ifid  = 1'b0;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      halted      = 1'b0;
      if (!rst) begin
         if (halt_now) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
            halted      = 1'b1;
         end else if (mem_stall) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
         end else if (branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
         end else if (hazard) begin
            stall_pc    = 1'b1;
            stall_ifid  = 1'b1;
            bubble_idex = 1'b1;
         end
      end
   end

   assign stall_cnt = cnt_q;
   assign err       = err_q;

   // control state: FSM, memory-stall watchdog, sticky error, stall counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         wd_cnt <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (halt_now) begin
            state  <= HALT;
            wd_cnt <= '0;
         end else if (mem_stall) begin
            state <= MWAIT;
            cnt_q <= sat_inc(cnt_q);
            if (!wd_inc[16])
               wd_cnt <= wd_inc[15:0];
            if (wd_inc >= 17'(MAX_MEM_STALL))
               err_q <= 1'b1;
         end else begin
            wd_cnt <= '0;
            if (branch_taken) begin
               state <= RUN;
            end else if (hazard) begin
               state <= HAZ;
               cnt_q <= sat_inc(cnt_q);
            end else begin
               state <= RUN;
            end
         end
      end
   end

   // shadow pipeline: EX -> MEM -> WB, bubble into EX on flush or stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_ex  <= '0;
         sh_mem <= '0;
         sh_wb  <= '0;
      end else if (!hold_shadow) begin
         sh_wb  <= sh_mem;
         sh_mem <= sh_ex;
         if (branch_taken | hazard)
            sh_ex <= '0;
         else
            sh_ex <= {id_valid & id_regwrite, id_writereg, id_valid & id_memread, id_valid & id_halt};
      end
   end

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_hazard_sched;

   localparam int MAXS  = 8;
   localparam int CNT_W = 6;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_SCHED_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             id_valid = 1'b0, id_uses_r1 = 1'b0, id_uses_r2 = 1'b0;
   logic [2:0]       id_read1sel = '0, id_read2sel = '0, id_writereg = '0;
   logic             id_regwrite = 1'b0, id_memread = 1'b0, id_halt = 1'b0;
   logic             branch_taken = 1'b0, mem_stall = 1'b0;
   logic             stall_pc, stall_ifid, bubble_idex, flush_ifid, halted, err;
   logic [CNT_W-1:0] stall_cnt;

   hazard_sched #(.MAX_MEM_STALL(MAXS), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_read1sel(id_read1sel),
      .id_read2sel(id_read2sel), .id_uses_r1(id_uses_r1), .id_uses_r2(id_uses_r2),
      .id_regwrite(id_regwrite), .id_writereg(id_writereg), .id_memread(id_memread),
      .id_halt(id_halt), .branch_taken(branch_taken), .mem_stall(mem_stall),
      .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
      .flush_ifid(flush_ifid), .halted(halted), .stall_cnt(stall_cnt), .err(err));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: instructions that left decode, youngest first (age 0 = one cycle ahead).
   typedef struct {
      bit       w;
      bit [2:0] rd;
      bit       ld;
      bit       h;
   } ins_t;

   ins_t pipe[$];
   int   m_cnt, m_run;
   bit   m_err, m_halted;
   bit   e_stall, e_ifid, e_bub, e_flush, e_halted;
   bit   o_stall, o_bub, o_flush, o_halted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit pending_write(input bit [2:0] s);
      if (FWD)
         return pipe[0].w && pipe[0].ld && pipe[0].rd == s;
      for (int a = 0; a < 2; a++)
         if (pipe[a].w && pipe[a].rd == s) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_hazard();
      return id_valid && ((id_uses_r1 && pending_write(id_read1sel)) ||
                          (id_uses_r2 && pending_write(id_read2sel)));
   endfunction

   function automatic bit m_haltnow();
      return m_halted || pipe[2].h;
   endfunction

   task automatic model_reset();
      ins_t b;
      b = '{default: 0};
      pipe.delete();
      for (int i = 0; i < 3; i++) pipe.push_back(b);
      m_cnt = 0; m_run = 0; m_err = 0; m_halted = 0;
   endtask

   task automatic model_outputs();
      bit hz;
      hz = m_hazard();
      {e_stall, e_ifid, e_bub, e_flush, e_halted} = '0;
      if (m_haltnow())       {e_stall, e_ifid, e_bub, e_halted} = 4'b1111;
      else if (mem_stall)    {e_stall, e_ifid} = 2'b11;
      else if (branch_taken) {e_flush, e_bub} = 2'b11;
      else if (hz)           {e_stall, e_ifid, e_bub} = 3'b111;
   endtask

   task automatic model_advance();
      bit   hn, hz;
      ins_t n;
      hn = m_haltnow();
      hz = m_hazard();
      if (!hn && (mem_stall || (!branch_taken && hz)) && m_cnt < CMAX) m_cnt++;
      if (!hn && mem_stall) begin
         m_run++;
         if (m_run >= MAXS) m_err = 1;
      end else begin
         m_run = 0;
      end
      if (!hn && !mem_stall) begin
         n = '{default: 0};
         if (!branch_taken && !hz) begin
            n.w  = id_valid && id_regwrite;
            n.rd = id_writereg;
            n.ld = id_valid && id_memread;
            n.h  = id_valid && id_halt;
         end
         pipe.push_front(n);
         void'(pipe.pop_back());
      end
      if (hn) m_halted = 1;
   endtask

   task automatic cycle();
      @(negedge clk);
      model_outputs();
      o_stall = stall_pc; o_bub = bubble_idex; o_flush = flush_ifid; o_halted = halted;
      chk("stall_pc", 32'(stall_pc), 32'(e_stall));
      chk("stall_ifid", 32'(stall_ifid), 32'(e_ifid));
      chk("bubble_idex", 32'(bubble_idex), 32'(e_bub));
      chk("flush_ifid", 32'(flush_ifid), 32'(e_flush));
      chk("halted", 32'(halted), 32'(e_halted));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic nop();
      id_valid = 0; id_uses_r1 = 0; id_uses_r2 = 0; id_regwrite = 0; id_memread = 0;
      id_halt = 0; branch_taken = 0; mem_stall = 0;
      id_read1sel = 0; id_read2sel = 0; id_writereg = 0;
   endtask

   task automatic set_insn(input bit [2:0] wr, input bit rw, input bit ld,
                           input bit [2:0] s1, input bit u1, input bit [2:0] s2, input bit u2);
      nop();
      id_valid = 1; id_writereg = wr; id_regwrite = rw; id_memread = ld;
      id_read1sel = s1; id_uses_r1 = u1; id_read2sel = s2; id_uses_r2 = u2;
   endtask

   task automatic run_insn(output int stalls);
      stalls = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (o_stall) stalls++;
         if (!e_stall) break;
      end
      nop();
   endtask

   task automatic do_reset();
      rst = 1;
      #1;
      chk("rst_stall_pc", 32'(stall_pc), 0);
      chk("rst_stall_ifid", 32'(stall_ifid), 0);
      chk("rst_bubble", 32'(bubble_idex), 0);
      chk("rst_flush", 32'(flush_ifid), 0);
      chk("rst_halted", 32'(halted), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      chk("rst_err", 32'(err), 0);
      @(posedge clk);
      #1;
      rst = 0;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      int st;
      do_reset();
      nop(); cycle();

      // dependent ALU op right behind its producer
      set_insn(3, 1, 0, 0, 0, 0, 0); cycle();
      set_insn(4, 1, 0, 3, 1, 1, 1); run_insn(st);
      chk("raw_stalls", st, FWD ? 0 : 2);
      chk("raw_cnt", 32'(stall_cnt), FWD ? 0 : 2);
      repeat (3) cycle();

      // load-use
      set_insn(2, 1, 1, 0, 0, 0, 0); cycle();
      set_insn(5, 1, 0, 2, 1, 2, 1); run_insn(st);
      chk("lu_stalls", st, FWD ? 1 : 2);
      chk("lu_cnt", 32'(stall_cnt), FWD ? 1 : 4);
      repeat (3) cycle();

      // hazard coinciding with a taken branch
      set_insn(6, 1, 1, 0, 0, 0, 0); cycle();
      set_insn(7, 1, 0, 6, 1, 0, 0); branch_taken = 1; cycle();
      chk("br_flush", 32'(o_flush), 1);
      chk("br_bubble", 32'(o_bub), 1);
      chk("br_stall", 32'(o_stall), 0);
      chk("br_cnt", 32'(stall_cnt), FWD ? 1 : 4);
      nop(); repeat (3) cycle();

      // memory stall over a pending hazard, then the watchdog
      set_insn(1, 1, 0, 0, 0, 0, 0); cycle();
      set_insn(2, 1, 0, 1, 1, 0, 0); mem_stall = 1;
      repeat (4) cycle();
      chk("ms_cnt", 32'(stall_cnt), FWD ? 5 : 8);
      mem_stall = 0; run_insn(st);
      chk("ms_stalls", st, FWD ? 0 : 2);
      mem_stall = 1; repeat (7) cycle();
      chk("wd_early", 32'(err), 0);
      cycle();
      chk("wd_err", 32'(err), 1);
      mem_stall = 0; repeat (2) cycle();
      chk("wd_sticky", 32'(err), 1);

      // HALT travels ex -> mem -> wb
      do_reset();
      nop(); id_valid = 1; id_halt = 1; cycle();
      nop(); cycle();
      chk("halt_c1", 32'(o_halted), 0);
      cycle();
      chk("halt_c2", 32'(o_halted), 0);
      cycle();
      chk("halt_c3", 32'(o_halted), 1);
      mem_stall = 1; cycle();
      branch_taken = 1; mem_stall = 0; cycle();
      chk("halt_frozen", 32'(o_halted), 1);
      chk("halt_cnt", 32'(stall_cnt), 0);

      // flushed HALT
      do_reset();
      nop(); id_valid = 1; id_halt = 1; branch_taken = 1; cycle();
      nop(); repeat (5) cycle();
      chk("halt_flushed", 32'(o_halted), 0);

      // reset while stalled
      set_insn(2, 1, 1, 0, 0, 0, 0); cycle();
      set_insn(3, 1, 0, 2, 1, 0, 0); cycle();
      chk("haz_before_rst", 32'(o_stall), 1);
      do_reset();
      set_insn(3, 1, 0, 2, 1, 0, 0); run_insn(st);
      chk("post_rst_stalls", st, 0);

      // randomized traffic
      do_reset();
      nop(); cycle();
      for (int i = 0; i < 400; i++) begin
         if (!e_stall) begin
            set_insn(3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                     3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom));
            id_valid = ($urandom_range(0, 7) != 0);
         end
         branch_taken = ($urandom_range(0, 7) == 0);
         mem_stall    = ($urandom_range(0, 9) == 0);
         cycle();
      end

      // counter saturation
      nop(); mem_stall = 1;
      repeat (70) cycle();
      chk("cnt_sat", 32'(stall_cnt), CMAX);
      chk("sat_err", 32'(err), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
